// File: rtl/traffic_light_monitor_pkg.sv
// Shared constants, phase/state encodings and sequencing rules for the light-bus monitor.
package traffic_pkg;

    localparam int LED_MAIN_RED = 6;
    localparam int LED_MAIN_YEL = 5;
    localparam int LED_MAIN_GRN = 4;
    localparam int LED_SIDE_RED = 3;
    localparam int LED_SIDE_YEL = 2;
    localparam int LED_SIDE_GRN = 1;
    localparam int LED_WALK     = 0;

    localparam logic [6:0] PAT_MG   = (7'd1 << LED_MAIN_GRN) | (7'd1 << LED_SIDE_RED);
    localparam logic [6:0] PAT_MY   = (7'd1 << LED_MAIN_YEL) | (7'd1 << LED_SIDE_RED);
    localparam logic [6:0] PAT_SG   = (7'd1 << LED_MAIN_RED) | (7'd1 << LED_SIDE_GRN);
    localparam logic [6:0] PAT_SY   = (7'd1 << LED_MAIN_RED) | (7'd1 << LED_SIDE_YEL);
    localparam logic [6:0] PAT_WALK = (7'd1 << LED_MAIN_RED) | (7'd1 << LED_SIDE_RED) | (7'd1 << LED_WALK);

    typedef enum logic [2:0] {
        PH_NONE = 3'd0,
        PH_MG   = 3'd1,
        PH_MY   = 3'd2,
        PH_SG   = 3'd3,
        PH_SY   = 3'd4,
        PH_WALK = 3'd5,
        PH_BAD  = 3'd7
    } phase_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRACK,
        ST_BAD
    } trk_state_t;

    function automatic phase_t decode_phase(logic [6:0] p);
        case (p)
            PAT_MG:   return PH_MG;
            PAT_MY:   return PH_MY;
            PAT_SG:   return PH_SG;
            PAT_SY:   return PH_SY;
            PAT_WALK: return PH_WALK;
            default:  return PH_BAD;
        endcase
    endfunction

    function automatic logic legal_trans(phase_t from, phase_t to);
        case (from)
            PH_MG:   return to == PH_MY;
            PH_MY:   return (to == PH_SG) || (to == PH_WALK);
            PH_WALK: return to == PH_SG;
            PH_SG:   return to == PH_SY;
            PH_SY:   return to == PH_MG;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Light-bus observation interface: the controller-side signals in, the monitor results out.
interface traffic_light_monitor_if #(parameter int DWELL_W = 5);
    logic [6:0]         LEDs;
    logic               oneHz_enable;
    logic               err_clear;
    logic [2:0]         phase;
    logic               phase_change;
    logic [DWELL_W-1:0] dwell;
    logic [DWELL_W-1:0] last_dwell;
    logic [2:0]         error;
    logic               fault;

    modport master (
        output LEDs, oneHz_enable, err_clear,
        input  phase, phase_change, dwell, last_dwell, error, fault
    );

    modport slave (
        input  LEDs, oneHz_enable, err_clear,
        output phase, phase_change, dwell, last_dwell, error, fault
    );
endinterface

// File: rtl/traffic_light_monitor_filter.sv
// Deglitch filter: a pattern must be seen FILTER_CYCLES samples in a row before it is accepted.
module led_filter #(
    parameter int FILTER_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] leds,
    output logic       accept,
    output logic [6:0] pattern
);
    localparam logic [3:0] FC = 4'(FILTER_CYCLES);

    logic [6:0] s_q, cand_q, acc_q;
    logic [3:0] cnt_q, cnt_d;

    // Accept is judged on the count about to be stored so the phase lands on edge FILTER_CYCLES+1.
    always_comb begin
        cnt_d = 4'd1;
        if (s_q == cand_q)
            cnt_d = (cnt_q >= FC) ? FC : cnt_q + 4'd1;
    end

    assign accept  = (cnt_d == FC) && (s_q != acc_q);
    assign pattern = s_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q    <= '0;
            cand_q <= '0;
            cnt_q  <= '0;
            acc_q  <= '0;
        end else begin
            s_q    <= leds;
            cand_q <= s_q;
            cnt_q  <= cnt_d;
            if (accept)
                acc_q <= s_q;
        end
    end
endmodule

// File: rtl/traffic_light_monitor.sv
// Passive light-bus monitor: phase tracking, dwell timing in seconds and sticky sequencing errors.
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int FILTER_CYCLES = 4,
    parameter int DWELL_W       = 5,
    parameter int MIN_YELLOW    = 2
) (
    input  logic                    clk,
    input  logic                    Reset,
    traffic_light_monitor_if.slave  bus
);
    localparam logic [DWELL_W-1:0] MIN_Y     = DWELL_W'(MIN_YELLOW);
    localparam logic [DWELL_W-1:0] DWELL_MAX = '1;

    logic               accept;
    logic [6:0]         pattern;
    phase_t             new_phase, phase_q;
    trk_state_t         state_q, state_d;
    logic [2:0]         err_set, error_q;
    logic [DWELL_W-1:0] dwell_q, last_q;
    logic               pc_q;

    led_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filter (
        .clk     (clk),
        .rst     (Reset),
        .leds    (bus.LEDs),
        .accept  (accept),
        .pattern (pattern)
    );

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        err_set   = '0;
        new_phase = decode_phase(pattern);
        if (accept) begin
            case (state_q)
                ST_IDLE:  state_d = (new_phase == PH_BAD) ? ST_BAD : ST_TRACK;
                ST_TRACK: begin
                    if (new_phase == PH_BAD) begin
                        err_set[0] = 1'b1;
                        state_d    = ST_BAD;
                    end else if (!legal_trans(phase_q, new_phase)) begin
                        err_set[1] = 1'b1;
                    end
                end
                ST_BAD:   if (new_phase != PH_BAD) state_d = ST_TRACK;
                default:  state_d = ST_IDLE;
            endcase
            if ((phase_q == PH_MY || phase_q == PH_SY) && dwell_q < MIN_Y)
                err_set[2] = 1'b1;
        end
    end

    // A strobe landing on the accept cycle is dropped: the new phase starts from zero.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            phase_q <= PH_NONE;
            pc_q    <= 1'b0;
            dwell_q <= '0;
            last_q  <= '0;
            error_q <= '0;
        end else begin
            pc_q    <= accept;
            error_q <= (bus.err_clear ? 3'b000 : error_q) | err_set;
            if (accept) begin
                phase_q <= new_phase;
                last_q  <= dwell_q;
                dwell_q <= '0;
            end else if (bus.oneHz_enable && state_q != ST_IDLE && dwell_q != DWELL_MAX) begin
                dwell_q <= dwell_q + 1'b1;
            end
        end
    end

    assign bus.phase        = phase_q;
    assign bus.phase_change = pc_q;
    assign bus.dwell        = dwell_q;
    assign bus.last_dwell   = last_q;
    assign bus.error        = error_q;
    assign bus.fault        = |error_q;
endmodule
